// File: rtl/mig_traffic_checker_if.sv
// MIG user (app) interface bundle.
// Master = traffic engine, slave = MIG.
interface mig_traffic_checker_if #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 256
);
  logic                  app_rdy;
  logic                  app_wdf_rdy;
  logic [DATA_W-1:0]     app_rd_data;
  logic                  app_rd_data_valid;
  logic [ADDR_W-1:0]     app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic [DATA_W-1:0]     app_wdf_data;
  logic [DATA_W/8-1:0]   app_wdf_mask;

  modport master (
    input  app_rdy,
    input  app_wdf_rdy,
    input  app_rd_data,
    input  app_rd_data_valid,
    output app_addr,
    output app_cmd,
    output app_en,
    output app_wdf_wren,
    output app_wdf_end,
    output app_wdf_data,
    output app_wdf_mask
  );

  modport slave (
    output app_rdy,
    output app_wdf_rdy,
    output app_rd_data,
    output app_rd_data_valid,
    input  app_addr,
    input  app_cmd,
    input  app_en,
    input  app_wdf_wren,
    input  app_wdf_end,
    input  app_wdf_data,
    input  app_wdf_mask
  );
endinterface

// File: rtl/mig_traffic_checker.sv
// Write/read-back traffic engine for the MIG app port.
// Writes BURSTS beats, reads them back, checks each.
module mig_traffic_checker #(
  parameter int          ADDR_W    = 29,
  parameter int          DATA_W    = 256,
  parameter int          BURSTS    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_STEP = 8,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        ui_clk,
  input  logic        sys_rst,
  input  logic        init_calib_complete,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  input  logic [31:0] seed,
  mig_traffic_checker_if.master app,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [15:0] first_err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT_RD,
    S_DONE
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [15:0] LAST = 16'(BURSTS - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  state_t r_state;
  state_t w_next;

  logic [1:0]        r_sel;
  logic [31:0]       r_seed;
  logic [15:0]       r_wi;
  logic [15:0]       r_ri;
  logic [15:0]       r_ci;
  logic [TW-1:0]     r_tcnt;
  logic [15:0]       r_err;
  logic [15:0]       r_first;
  logic              r_to;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_cmd;
  logic [DATA_W-1:0] r_wdata;

  logic              w_start;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_chk;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_to_hit;
  logic              w_mis;
  logic              w_en;
  logic              w_wren;
  logic [DATA_W-1:0] w_exp;

  // Beat pattern generator, 32-bit lanes, arithmetic mod 2^32.
  function automatic logic [DATA_W-1:0] f_pat(
    input logic [1:0]  sel,
    input logic [31:0] sd,
    input logic [15:0] idx
  );
    logic [DATA_W-1:0] v;
    int unsigned       bp;
    v  = '0;
    bp = 32'(idx) % DATA_W;
    for (int k = 0; k < DATA_W / 32; k++) begin
      case (sel)
        2'd0: v[k*32 +: 32] = sd + 32'(idx);
        2'd1: v[k*32 +: 32] = 32'(BASE_ADDR)
                            + 32'(idx) * 32'(ADDR_STEP)
                            + 32'(k);
        2'd2: v[k*32 +: 32] = '0;
        default: v[k*32 +: 32] = ~(sd + 32'(idx));
      endcase
    end
    if (sel == 2'd2) begin
      v = {{(DATA_W-1){1'b0}}, 1'b1} << bp;
    end
    return v;
  endfunction

  assign w_start  = start & init_calib_complete &
                    ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_wr_acc = (r_state == S_WRITE) &
                    app.app_rdy & app.app_wdf_rdy;
  assign w_rd_acc = (r_state == S_READ) & app.app_rdy;
  assign w_chk    = (r_state == S_READ) | (r_state == S_WAIT_RD);
  assign w_beat   = w_chk & app.app_rd_data_valid;
  assign w_last_beat = w_beat & (r_ci == LAST);
  assign w_exp    = f_pat(r_sel, r_seed, r_ci);
  assign w_mis    = w_beat & (app.app_rd_data != w_exp);
  assign w_to_hit = w_chk & ~app.app_rd_data_valid &
                    (r_ci < r_ri) & (r_tcnt == TLAST);

  // State register.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state, command strobes and status flags.
  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_wren = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    pass   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        w_en   = app.app_rdy & app.app_wdf_rdy;
        w_wren = w_en;
        if (w_wr_acc && r_wi == LAST) w_next = S_READ;
      end
      S_READ: begin
        busy = 1'b1;
        w_en = 1'b1;
        if (w_last_beat || w_to_hit) begin
          w_next = S_DONE;
        end else if (w_rd_acc && r_ri == LAST) begin
          w_next = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        busy = 1'b1;
        if (w_last_beat || w_to_hit) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (r_err == 16'd0) & ~r_to;
        if (w_start) w_next = S_WRITE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command side: beat indices, address and write data.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_sel   <= '0;
      r_seed  <= '0;
      r_wi    <= '0;
      r_ri    <= '0;
      r_addr  <= '0;
      r_cmd   <= CMD_WR;
      r_wdata <= '0;
    end else if (w_start) begin
      r_sel   <= pattern_sel;
      r_seed  <= seed;
      r_wi    <= '0;
      r_ri    <= '0;
      r_addr  <= BASE;
      r_cmd   <= CMD_WR;
      r_wdata <= f_pat(pattern_sel, seed, 16'd0);
    end else if (w_wr_acc) begin
      r_wi <= r_wi + 16'd1;
      if (r_wi == LAST) begin
        r_addr <= BASE;
        r_cmd  <= CMD_RD;
      end else begin
        r_addr  <= r_addr + STEP;
        r_wdata <= f_pat(r_sel, r_seed, r_wi + 16'd1);
      end
    end else if (w_rd_acc) begin
      r_ri   <= r_ri + 16'd1;
      r_addr <= r_addr + STEP;
    end
  end

  // Check side: compare returned beats, errors, timeout.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_ci    <= '0;
      r_tcnt  <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_to    <= 1'b0;
    end else if (w_start) begin
      r_ci    <= '0;
      r_tcnt  <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_to    <= 1'b0;
    end else if (w_beat) begin
      r_ci   <= r_ci + 16'd1;
      r_tcnt <= '0;
      if (w_mis) begin
        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
        if (r_err == 16'd0)    r_first <= r_ci;
      end
    end else if (w_to_hit) begin
      r_to <= 1'b1;
    end else if (w_chk && (r_ci < r_ri)) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign app.app_addr     = r_addr;
  assign app.app_cmd      = r_cmd;
  assign app.app_wdf_data = r_wdata;
  assign app.app_wdf_mask = '0;
  assign app.app_en       = w_en;
  assign app.app_wdf_wren = w_wren;
  assign app.app_wdf_end  = w_wren;

  assign timeout       = r_to;
  assign err_cnt       = r_err;
  assign first_err_idx = r_first;

endmodule

// File: tb/tb_mig_traffic_checker.sv
// Directed bench for mig_traffic_checker.
// Two engines: short 10-beat run and a 300-beat wrap run.
module tb_mig_traffic_checker;
  localparam int DW = 256;
  localparam int AW = 29;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        calib;
  logic        start_a;
  logic        start_b;
  logic [1:0]  sel;
  logic [31:0] seed;

  logic        busy_a, done_a, pass_a, to_a;
  logic [15:0] ec_a, fe_a;
  logic        busy_b, done_b, pass_b, to_b;
  logic [15:0] ec_b, fe_b;

  int checks = 0;
  int errors = 0;

  mig_traffic_checker_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
  mig_traffic_checker_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

  mig_traffic_checker #(
    .ADDR_W(AW), .DATA_W(DW), .BURSTS(10),
    .BASE_ADDR(0), .ADDR_STEP(8), .TIMEOUT(64)
  ) dut_a (
    .ui_clk(clk), .sys_rst(rst_n),
    .init_calib_complete(calib), .start(start_a),
    .pattern_sel(sel), .seed(seed), .app(ifa),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .timeout(to_a), .err_cnt(ec_a), .first_err_idx(fe_a)
  );

  mig_traffic_checker #(
    .ADDR_W(AW), .DATA_W(DW), .BURSTS(300),
    .BASE_ADDR(32'h1FFF_FFF8), .ADDR_STEP(8), .TIMEOUT(4096)
  ) dut_b (
    .ui_clk(clk), .sys_rst(rst_n),
    .init_calib_complete(calib), .start(start_b),
    .pattern_sel(sel), .seed(seed), .app(ifb),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .timeout(to_b), .err_cnt(ec_b), .first_err_idx(fe_b)
  );

  // MIG model A: memory, 1-cycle read return, fault knobs.
  logic [DW-1:0] mem_a [logic [AW-1:0]];
  logic [AW-1:0] rq_a [$];
  logic [AW-1:0] wa_a [$];
  logic [DW-1:0] wd_a [$];
  int bad_a = 0;
  int nrd_a = 0;
  int ret_a = 0;
  bit rnd_rdy = 0;
  bit no_resp = 0;
  logic [15:0] corrupt = '0;
  logic [AW-1:0] ma_a;
  logic [DW-1:0] md_a;

  always @(posedge clk) begin
    if (!rst_n) begin
      rq_a.delete();
    end else begin
      if (ifa.app_wdf_wren) begin
        if (!(ifa.app_rdy && ifa.app_wdf_rdy && ifa.app_en &&
              ifa.app_wdf_end && ifa.app_cmd == 3'b000))
          bad_a++;
        mem_a[ifa.app_addr] = ifa.app_wdf_data;
        wa_a.push_back(ifa.app_addr);
        wd_a.push_back(ifa.app_wdf_data);
      end
      if (ifa.app_en && ifa.app_cmd == 3'b000 && !ifa.app_wdf_wren)
        bad_a++;
      if (ifa.app_en && ifa.app_rdy && ifa.app_cmd == 3'b001) begin
        rq_a.push_back(ifa.app_addr);
        nrd_a++;
      end
    end
  end

  always @(negedge clk) begin
    ifa.app_rd_data_valid = 1'b0;
    if (rnd_rdy) begin
      ifa.app_rdy     = 1'($urandom_range(0, 1));
      ifa.app_wdf_rdy = 1'($urandom_range(0, 1));
    end else begin
      ifa.app_rdy     = 1'b1;
      ifa.app_wdf_rdy = 1'b1;
    end
    if (rst_n && !no_resp && rq_a.size() > 0) begin
      ma_a = rq_a.pop_front();
      md_a = mem_a.exists(ma_a) ? mem_a[ma_a] : '0;
      if (ret_a < 16 && corrupt[ret_a]) md_a[3] = ~md_a[3];
      ret_a++;
      ifa.app_rd_data       = md_a;
      ifa.app_rd_data_valid = 1'b1;
    end
  end

  // MIG model B: ideal, always ready.
  logic [DW-1:0] mem_b [logic [AW-1:0]];
  logic [AW-1:0] rq_b [$];
  logic [AW-1:0] wa_b [$];
  logic [DW-1:0] wd_b [$];
  logic [AW-1:0] ma_b;

  always @(posedge clk) begin
    if (!rst_n) begin
      rq_b.delete();
    end else begin
      if (ifb.app_wdf_wren) begin
        mem_b[ifb.app_addr] = ifb.app_wdf_data;
        wa_b.push_back(ifb.app_addr);
        wd_b.push_back(ifb.app_wdf_data);
      end
      if (ifb.app_en && ifb.app_rdy && ifb.app_cmd == 3'b001)
        rq_b.push_back(ifb.app_addr);
    end
  end

  always @(negedge clk) begin
    ifb.app_rd_data_valid = 1'b0;
    ifb.app_rdy           = 1'b1;
    ifb.app_wdf_rdy       = 1'b1;
    if (rst_n && rq_b.size() > 0) begin
      ma_b = rq_b.pop_front();
      ifb.app_rd_data = mem_b.exists(ma_b) ? mem_b[ma_b] : '0;
      ifb.app_rd_data_valid = 1'b1;
    end
  end

  task automatic chkw(input string tag,
                      input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic run_a(input logic [1:0] s, input logic [31:0] sd);
    wa_a.delete();
    wd_a.delete();
    ret_a = 0;
    nrd_a = 0;
    bad_a = 0;
    sel = s;
    seed = sd;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic run_b(input logic [1:0] s, input logic [31:0] sd);
    wa_b.delete();
    wd_b.delete();
    sel = s;
    seed = sd;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_a(input int lim);
    int n = 0;
    while (!done_a && n < lim) begin
      @(negedge clk);
      n++;
    end
    chkb("done_a_in_bound", done_a, 1'b1);
  endtask

  task automatic wait_b(input int lim);
    int n = 0;
    while (!done_b && n < lim) begin
      @(negedge clk);
      n++;
    end
    chkb("done_b_in_bound", done_b, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] e;
    int n;
    rst_n   = 1'b0;
    calib   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    sel     = 2'd0;
    seed    = '0;
    repeat (3) @(negedge clk);

    chkb("rst_busy", busy_a, 1'b0);
    chkb("rst_done", done_a, 1'b0);
    chkb("rst_pass", pass_a, 1'b0);
    chkb("rst_en", ifa.app_en, 1'b0);
    chkw("rst_addr", DW'(ifa.app_addr), '0);
    chkw("rst_wdata", ifa.app_wdf_data, '0);
    chkw("rst_errcnt", DW'(ec_a), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run, pattern 0, seed 0.
    run_a(2'd0, 32'd0);
    chkb("busy_after_start", busy_a, 1'b1);
    chkb("wren_first_cycle", ifa.app_wdf_wren, 1'b1);
    wait_a(200);
    chkb("p0_pass", pass_a, 1'b1);
    chkb("p0_busy_end", busy_a, 1'b0);
    chkb("p0_timeout", to_a, 1'b0);
    chkw("p0_errcnt", DW'(ec_a), '0);
    chkw("p0_nwr", DW'(wa_a.size()), DW'(10));
    chkw("p0_nrd", DW'(nrd_a), DW'(10));
    for (int i = 0; i < 10; i++) begin
      chkw("p0_addr", DW'(wa_a[i]), DW'(i * 8));
      chkw("p0_data", wd_a[i], {8{32'(i)}});
    end

    // Pattern 3 with a seed.
    run_a(2'd3, 32'h100);
    wait_a(200);
    chkb("p3_pass", pass_a, 1'b1);
    chkw("p3_beat0", wd_a[0], {8{32'hFFFF_FEFF}});
    chkw("p3_beat2", wd_a[2], {8{32'hFFFF_FEFD}});

    // Random ready flags.
    rnd_rdy = 1'b1;
    run_a(2'd0, 32'd0);
    wait_a(2000);
    rnd_rdy = 1'b0;
    chkb("rnd_pass", pass_a, 1'b1);
    chkw("rnd_nwr", DW'(wa_a.size()), DW'(10));
    chkw("rnd_bad", DW'(bad_a), '0);
    chkw("rnd_nrd", DW'(nrd_a), DW'(10));
    chkw("rnd_addr9", DW'(wa_a[9]), DW'(72));
    chkw("rnd_data9", wd_a[9], {8{32'd9}});

    // Corrupted beats 4 and 7.
    corrupt = 16'h0090;
    run_a(2'd0, 32'd0);
    wait_a(200);
    corrupt = '0;
    chkw("cor_errcnt", DW'(ec_a), DW'(2));
    chkw("cor_first", DW'(fe_a), DW'(4));
    chkb("cor_pass", pass_a, 1'b0);
    chkb("cor_timeout", to_a, 1'b0);

    // No read data: timeout.
    no_resp = 1'b1;
    run_a(2'd0, 32'd0);
    repeat (40) @(negedge clk);
    chkb("to_not_early", done_a, 1'b0);
    wait_a(300);
    chkb("to_flag", to_a, 1'b1);
    chkb("to_pass", pass_a, 1'b0);
    no_resp = 1'b0;
    repeat (15) @(negedge clk);
    chkb("to_hold_done", done_a, 1'b1);
    chkb("to_hold_flag", to_a, 1'b1);
    chkw("to_late_ignored", DW'(ec_a), '0);

    // Reset in the middle of READ.
    run_a(2'd0, 32'd0);
    n = 0;
    while (ifa.app_cmd != 3'b001 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chkw("mid_cmd_read", DW'(ifa.app_cmd), DW'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chkb("mid_rst_busy", busy_a, 1'b0);
    chkb("mid_rst_en", ifa.app_en, 1'b0);
    chkw("mid_rst_addr", DW'(ifa.app_addr), '0);
    chkw("mid_rst_wdata", ifa.app_wdf_data, '0);
    chkb("mid_rst_done", done_a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_a(2'd0, 32'd0);
    wait_a(200);
    chkb("post_rst_pass", pass_a, 1'b1);
    chkw("post_rst_nwr", DW'(wa_a.size()), DW'(10));

    // start without calibration.
    calib = 1'b0;
    run_a(2'd0, 32'd0);
    repeat (20) @(negedge clk);
    chkb("nocal_busy", busy_a, 1'b0);
    chkw("nocal_nwr", DW'(wa_a.size()), '0);
    chkb("nocal_done_held", done_a, 1'b1);
    calib = 1'b1;

    // Pattern 2 across 300 beats.
    run_b(2'd2, 32'd0);
    wait_b(1000);
    chkb("p2_pass", pass_b, 1'b1);
    chkw("p2_nwr", DW'(wd_b.size()), DW'(300));
    e = '0;
    e[0] = 1'b1;
    chkw("p2_beat256", wd_b[256], e);
    e = '0;
    e[255] = 1'b1;
    chkw("p2_beat255", wd_b[255], e);
    e = '0;
    e[31] = 1'b1;
    chkw("p2_beat31", wd_b[31], e);

    // Pattern 1 with address wrap.
    run_b(2'd1, 32'd0);
    wait_b(1000);
    chkb("p1_pass", pass_b, 1'b1);
    chkw("p1_addr0", DW'(wa_b[0]), DW'(29'h1FFF_FFF8));
    chkw("p1_addr1", DW'(wa_b[1]), '0);
    chkw("p1_b0_l0", DW'(wd_b[0][31:0]), DW'(32'h1FFF_FFF8));
    chkw("p1_b1_l0", DW'(wd_b[1][31:0]), DW'(32'h2000_0000));
    chkw("p1_b1_l7", DW'(wd_b[1][255:224]), DW'(32'h2000_0007));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
